nx_init_loader: RTL and testbench
=================================

Name: nx_init_loader

Overview:
Boot-time initialisation sequencer for nx_riscv_top. Accepts a stream of load commands over a valid/ready handshake and steers each command into exactly one target: the instruction-RAM write port, the data-RAM initial write port, or the regfile initial write port. Holds the core in reset during loading. After a GO command and a programmable hold time, it releases the core. Replaces hand-timed per-port write tasks with a single arbitrated, checked loader.

Parameters:
IMEM_DEPTH, 1024, instruction RAM depth in 32-bit words; power of two
DMEM_DEPTH, 1024, data RAM depth in 32-bit words; power of two
RST_HOLD, 16, cycles core_rst_n stays low after GO is accepted; minimum 1

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  loader can accept a command this cycle
cmd_type  in  2  00 inst write, 01 data write, 10 regfile write, 11 GO
cmd_addr  in  32  byte address for inst/data; [4:0] = register index for regfile
cmd_data  in  32  write data; GO: expected checksum (see optional feature)
inst_ram_wen  out  1  instruction RAM write strobe
inst_ram_waddr  out  32  instruction RAM byte address
inst_ram_wdata  out  32  instruction RAM write data
data_ram_wen_initial  out  1  data RAM write strobe
data_ram_waddr_initial  out  32  data RAM byte address
data_ram_wdata_initial  out  32  data RAM write data
regfile_wen_initial  out  1  regfile write strobe
regfile_waddr_initial  out  5  register index
regfile_wdata_initial  out  32  register data
core_rst_n  out  1  reset to the core; low while loading
load_err  out  1  sticky: at least one command was rejected
wr_count  out  16  accepted-and-performed writes; saturates at 0xFFFF
checksum  out  32  running checksum; 0 when the feature is compiled out

Behaviour:
- Reset is synchronous: on a clk edge with rst_n=0, all outputs go to 0 (core_rst_n=0) and the state goes to LOAD. Reset mid-operation aborts any hold count and re-enters LOAD; nothing is written in the reset cycle.
- States:
  - LOAD: cmd_ready=1. A handshake is cmd_valid&cmd_ready at the clk edge.
    - Write types go to LOAD, staying there.
    - GO goes to HOLD. With the checksum feature enabled, a GO checksum mismatch stays in LOAD instead.
  - HOLD: cmd_ready=0. A counter loads RST_HOLD-1 and decrements each cycle. At 0 the state goes to RUN.
  - RUN: cmd_ready=0 and core_rst_n=1, registered. RUN is terminal until rst_n.
- Timing:
  - Every accepted write drives its target's wen high for exactly one cycle, in the cycle after the handshake. All outputs are registered; latency is 1.
  - Addr/data outputs hold their last value when wen=0.
  - At most one target strobe is high per cycle; the strobes are mutually exclusive by construction.
  - Throughput is one command per cycle, with back-to-back commands supported.
- Checks: a rejected command produces no strobe, sets load_err, and is still consumed (ready is not deasserted).
  - inst: cmd_addr[1:0]!=0 or cmd_addr[31:2]>=IMEM_DEPTH is rejected.
  - data: same check against DMEM_DEPTH.
  - regfile: cmd_addr[31:5]!=0 is rejected. Index 0 is silently dropped: no strobe, no error, no count.
- wr_count increments in the strobe cycle and saturates at 0xFFFF without wrapping.
- core_rst_n is low in LOAD and HOLD. It rises on the cycle after the HOLD counter reaches 0, i.e. RST_HOLD+1 cycles after the GO handshake.
- cmd_valid while not ready is ignored. The source holds it.

Optional Feature:
NX_LOADER_CHECKSUM_EN
- Defined:
  - checksum resets to 0.
  - On each performed write it updates as checksum += wdata, mod 2^32; dropped or rejected writes are excluded.
  - On GO, cmd_data is compared with the current checksum, including any write strobing in the same cycle as the GO handshake.
  - Match: proceed to HOLD.
  - Mismatch: set load_err and remain in LOAD, so the host may reload and retry GO.
- Undefined: checksum is tied to 0, cmd_data on GO is ignored, and GO always proceeds.

Decomposition:
- Package nx_loader_pkg:
  - cmd_type encodings CMD_INST/CMD_DATA/CMD_REG/CMD_GO
  - state encodings LOAD/HOLD/RUN
  - counter widths
- Sub-module nx_loader_addr_chk (combinational): range/alignment check per target, producing accept/drop/reject. The FSM, strobes and counters stay in the top.

Test Plan:
- Reset, then inst write addr 0 data 0x00208033, regfile writes x1=38, x2=22 back-to-back: inst_ram_wen pulses cycle+1, then regfile strobes on two consecutive cycles, wr_count=3, core_rst_n=0.
- GO with RST_HOLD=16: cmd_ready drops the next cycle, core_rst_n rises exactly 17 cycles after the handshake, further cmd_valid is ignored.
- inst addr 0x2 (misaligned) and data addr 4*DMEM_DEPTH: no strobes, load_err=1, wr_count unchanged, the next valid write is still performed.
- regfile index 0 data 0xDEAD: no strobe, load_err stays 0, wr_count unchanged. cmd_addr=0x20: load_err=1.
- rst_n low for 1 cycle during HOLD: core_rst_n stays 0, state returns to LOAD, all counters and load_err clear.
- With NX_LOADER_CHECKSUM_EN, write 0x10 and 0x20:
  - GO with data 0x31: stays in LOAD, load_err=1.
  - GO with 0x30: core_rst_n rises after the hold.

Source files
------------

// File: rtl/nx_loader_pkg.sv
// nx_loader_pkg: shared encodings and widths for the nx_init_loader boot sequencer.
package nx_loader_pkg;
  typedef enum logic [1:0] {
    CMD_INST = 2'b00,
    CMD_DATA = 2'b01,
    CMD_REG  = 2'b10,
    CMD_GO   = 2'b11
  } cmd_e;
  typedef enum logic [1:0] {LOAD, HOLD, RUN} state_e;
  typedef enum logic [1:0] {ACCEPT, DROP, REJECT} verdict_e;
  localparam int HOLD_W = 16;
  localparam int WR_CNT_W = 16;
endpackage

// File: rtl/nx_loader_addr_chk.sv
// nx_loader_addr_chk: classifies a load command's target address as accept, drop or reject.
module nx_loader_addr_chk
  import nx_loader_pkg::*;
#(
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 1024
) (
  input  logic [1:0]  cmd_type,
  input  logic [31:0] cmd_addr,
  output verdict_e    verdict
);
  logic [31:0] word;
  logic aligned;
  assign word = {2'b00, cmd_addr[31:2]};
  assign aligned = cmd_addr[1:0] == 2'b00;
  // x0 is hardwired in the core, so writing it is a silent no-op rather than an error
  always_comb
    verdict = cmd_type == CMD_INST ? (aligned && word < 32'(IMEM_DEPTH) ? ACCEPT : REJECT)
            : cmd_type == CMD_DATA ? (aligned && word < 32'(DMEM_DEPTH) ? ACCEPT : REJECT)
            : cmd_type == CMD_REG  ? (cmd_addr[31:5] != '0 ? REJECT : cmd_addr[4:0] == '0 ? DROP : ACCEPT)
            : ACCEPT;
endmodule

// File: rtl/nx_init_loader.sv
// nx_init_loader: boot-time loader steering commands to imem/dmem/regfile and releasing core reset.
// Optional GO checksum verification enabled by defining NX_LOADER_CHECKSUM_EN.
module nx_init_loader
  import nx_loader_pkg::*;
#(
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 1024,
  parameter int RST_HOLD   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_type,
  input  logic [31:0]         cmd_addr,
  input  logic [31:0]         cmd_data,
  output logic                inst_ram_wen,
  output logic [31:0]         inst_ram_waddr,
  output logic [31:0]         inst_ram_wdata,
  output logic                data_ram_wen_initial,
  output logic [31:0]         data_ram_waddr_initial,
  output logic [31:0]         data_ram_wdata_initial,
  output logic                regfile_wen_initial,
  output logic [4:0]          regfile_waddr_initial,
  output logic [31:0]         regfile_wdata_initial,
  output logic                core_rst_n,
  output logic                load_err,
  output logic [WR_CNT_W-1:0] wr_count,
  output logic [31:0]         checksum
);
  state_e state, state_n;
  verdict_e verdict;
  logic [HOLD_W-1:0] cnt, cnt_n;
  logic hs, wr_ok, is_go, go_ok;
  nx_loader_addr_chk #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH)) u_chk (
    .cmd_type(cmd_type),
    .cmd_addr(cmd_addr),
    .verdict(verdict)
  );
  assign hs = cmd_valid & cmd_ready;
  assign is_go = hs && cmd_type == CMD_GO;
  assign wr_ok = hs && cmd_type != CMD_GO && verdict == ACCEPT;
`ifdef NX_LOADER_CHECKSUM_EN
  // the register already includes the write strobing alongside a GO handshake
  always_ff @(posedge clk)
    if (!rst_n) checksum <= '0;
    else if (wr_ok) checksum <= checksum + cmd_data;
  assign go_ok = cmd_data == checksum;
`else
  assign checksum = '0;
  assign go_ok = 1'b1;
`endif
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= LOAD;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  always_comb begin
    state_n = state == LOAD && is_go && go_ok ? HOLD : state == HOLD && cnt == '0 ? RUN : state;
    cnt_n = state == HOLD ? cnt - 1'b1 : HOLD_W'(RST_HOLD - 1);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      cmd_ready <= 1'b0;
      core_rst_n <= 1'b0;
      load_err <= 1'b0;
      wr_count <= '0;
      inst_ram_wen <= 1'b0;
      inst_ram_waddr <= '0;
      inst_ram_wdata <= '0;
      data_ram_wen_initial <= 1'b0;
      data_ram_waddr_initial <= '0;
      data_ram_wdata_initial <= '0;
      regfile_wen_initial <= 1'b0;
      regfile_waddr_initial <= '0;
      regfile_wdata_initial <= '0;
    end else begin
      cmd_ready <= state_n == LOAD;
      core_rst_n <= state == RUN;
      load_err <= load_err | (hs && verdict == REJECT) | (is_go && !go_ok);
      if (wr_ok && wr_count != '1) wr_count <= wr_count + 1'b1;
      inst_ram_wen <= wr_ok && cmd_type == CMD_INST;
      data_ram_wen_initial <= wr_ok && cmd_type == CMD_DATA;
      regfile_wen_initial <= wr_ok && cmd_type == CMD_REG;
      if (wr_ok && cmd_type == CMD_INST) begin
        inst_ram_waddr <= cmd_addr;
        inst_ram_wdata <= cmd_data;
      end
      if (wr_ok && cmd_type == CMD_DATA) begin
        data_ram_waddr_initial <= cmd_addr;
        data_ram_wdata_initial <= cmd_data;
      end
      if (wr_ok && cmd_type == CMD_REG) begin
        regfile_waddr_initial <= cmd_addr[4:0];
        regfile_wdata_initial <= cmd_data;
      end
    end
endmodule

// File: tb/tb_nx_init_loader.sv
// tb_nx_init_loader: randomized bench for nx_init_loader against a cycle-count level reference model.
module tb_nx_init_loader;
  import nx_loader_pkg::*;
  localparam int IMEM_DEPTH = 1024;
  localparam int DMEM_DEPTH = 1024;
  localparam int RST_HOLD = 16;
  logic clk, rst_n, cmd_valid, cmd_ready;
  logic [1:0] cmd_type;
  logic [31:0] cmd_addr, cmd_data;
  logic inst_ram_wen, data_ram_wen_initial, regfile_wen_initial;
  logic [31:0] inst_ram_waddr, inst_ram_wdata, data_ram_waddr_initial, data_ram_wdata_initial;
  logic [4:0] regfile_waddr_initial;
  logic [31:0] regfile_wdata_initial, checksum;
  logic core_rst_n, load_err;
  logic [15:0] wr_count;
  int total = 0, passed = 0;
  bit chk_on = 0;
  // reference model: expectations after the most recent clock edge
  bit m_ready, m_go, m_crst, m_err, m_iw, m_dw, m_rw;
  int m_since, m_cnt;
  logic [31:0] m_sum, m_ia, m_id, m_da, m_dd, m_rd;
  logic [4:0] m_ra;

  nx_init_loader #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH), .RST_HOLD(RST_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .inst_ram_wen(inst_ram_wen), .inst_ram_waddr(inst_ram_waddr), .inst_ram_wdata(inst_ram_wdata),
    .data_ram_wen_initial(data_ram_wen_initial), .data_ram_waddr_initial(data_ram_waddr_initial),
    .data_ram_wdata_initial(data_ram_wdata_initial), .regfile_wen_initial(regfile_wen_initial),
    .regfile_waddr_initial(regfile_waddr_initial), .regfile_wdata_initial(regfile_wdata_initial),
    .core_rst_n(core_rst_n), .load_err(load_err), .wr_count(wr_count), .checksum(checksum)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic performed(input logic [31:0] d);
    if (m_cnt < 65535) m_cnt++;
`ifdef NX_LOADER_CHECKSUM_EN
    m_sum += d;
`endif
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      {m_ready, m_go, m_crst, m_err, m_iw, m_dw, m_rw} = '0;
      m_since = 0; m_cnt = 0; m_sum = 0;
      m_ia = 0; m_id = 0; m_da = 0; m_dd = 0; m_ra = 0; m_rd = 0;
    end else begin
      {m_iw, m_dw, m_rw} = '0;
      if (m_go) m_since++;
      if (cmd_valid && m_ready) begin
        if (cmd_type == CMD_INST) begin
          if (cmd_addr % 4 == 0 && cmd_addr / 4 < IMEM_DEPTH) begin
            m_iw = 1; m_ia = cmd_addr; m_id = cmd_data; performed(cmd_data);
          end else m_err = 1;
        end else if (cmd_type == CMD_DATA) begin
          if (cmd_addr % 4 == 0 && cmd_addr / 4 < DMEM_DEPTH) begin
            m_dw = 1; m_da = cmd_addr; m_dd = cmd_data; performed(cmd_data);
          end else m_err = 1;
        end else if (cmd_type == CMD_REG) begin
          if (cmd_addr > 31) m_err = 1;
          else if (cmd_addr != 0) begin
            m_rw = 1; m_ra = cmd_addr[4:0]; m_rd = cmd_data; performed(cmd_data);
          end
        end else begin
`ifdef NX_LOADER_CHECKSUM_EN
          if (cmd_data == m_sum) begin m_go = 1; m_since = 0; end
          else m_err = 1;
`else
          m_go = 1; m_since = 0;
`endif
        end
      end
      m_ready = !m_go;
      m_crst = m_go && m_since >= RST_HOLD + 1;
    end
  end

  always @(negedge clk)
    if (chk_on) begin
      check("cmd_ready", 32'(cmd_ready), 32'(m_ready));
      check("core_rst_n", 32'(core_rst_n), 32'(m_crst));
      check("load_err", 32'(load_err), 32'(m_err));
      check("wr_count", 32'(wr_count), 32'(m_cnt));
      check("checksum", checksum, m_sum);
      check("inst_wen", 32'(inst_ram_wen), 32'(m_iw));
      check("inst_addr", inst_ram_waddr, m_ia);
      check("inst_data", inst_ram_wdata, m_id);
      check("data_wen", 32'(data_ram_wen_initial), 32'(m_dw));
      check("data_addr", data_ram_waddr_initial, m_da);
      check("data_data", data_ram_wdata_initial, m_dd);
      check("reg_wen", 32'(regfile_wen_initial), 32'(m_rw));
      check("reg_addr", 32'(regfile_waddr_initial), 32'(m_ra));
      check("reg_data", regfile_wdata_initial, m_rd);
    end

  task automatic send(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    cmd_valid = 1; cmd_type = t; cmd_addr = a; cmd_data = d;
  endtask

  task automatic idle();
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; cmd_valid = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  function automatic logic [31:0] rand_addr(input logic [1:0] t);
    int k = $urandom_range(0, 7);
    if (t == CMD_REG) return k == 0 ? 32'($urandom) : k == 1 ? 32'h0 : k == 2 ? 32'h20 : 32'($urandom_range(0, 31));
    return k == 0 ? 32'($urandom) : k == 1 ? 32'($urandom_range(0, 1023) * 4 + $urandom_range(1, 3))
         : k == 2 ? 32'd4096 : k == 3 ? 32'd4092 : 32'($urandom_range(0, 1023) * 4);
  endfunction

  initial begin
    rst_n = 0; cmd_valid = 0; cmd_type = 0; cmd_addr = 0; cmd_data = 0;
    do_reset();
    chk_on = 1;
    check("rst_wr_count", 32'(wr_count), 0);
    check("rst_core_rst_n", 32'(core_rst_n), 0);
    check("rst_load_err", 32'(load_err), 0);
    send(CMD_INST, 0, 32'h00208033);
    send(CMD_REG, 1, 38);
    check("lit_inst_wen", 32'(inst_ram_wen), 1);
    check("lit_inst_wdata", inst_ram_wdata, 32'h00208033);
    send(CMD_REG, 2, 22);
    check("lit_reg1_addr", 32'(regfile_waddr_initial), 1);
    check("lit_reg1_data", regfile_wdata_initial, 38);
    idle();
    check("lit_reg2_wen", 32'(regfile_wen_initial), 1);
    check("lit_reg2_addr", 32'(regfile_waddr_initial), 2);
    check("lit_reg2_data", regfile_wdata_initial, 22);
    check("lit_wr_count3", 32'(wr_count), 3);
    send(CMD_REG, 0, 32'hDEAD);
    idle();
    check("lit_x0_wen", 32'(regfile_wen_initial), 0);
    check("lit_x0_err", 32'(load_err), 0);
    check("lit_x0_count", 32'(wr_count), 3);
    send(CMD_REG, 32'h20, 5);
    idle();
    check("lit_reg_oob_err", 32'(load_err), 1);
    send(CMD_INST, 2, 7);
    send(CMD_DATA, 4 * DMEM_DEPTH, 9);
    idle();
    check("lit_rej_dwen", 32'(data_ram_wen_initial), 0);
    check("lit_rej_count", 32'(wr_count), 3);
    send(CMD_DATA, 8, 32'h55);
    idle();
    check("lit_after_rej_dwen", 32'(data_ram_wen_initial), 1);
    check("lit_after_rej_count", 32'(wr_count), 4);
    send(CMD_GO, 0, m_sum);
    @(negedge clk);
    cmd_type = CMD_INST; cmd_addr = 12; cmd_data = 1;
    check("lit_go_ready", 32'(cmd_ready), 0);
    repeat (16) @(negedge clk);
    check("lit_hold16", 32'(core_rst_n), 0);
    @(negedge clk);
    check("lit_hold17", 32'(core_rst_n), 1);
    check("lit_ignored_count", 32'(wr_count), 4);
    cmd_valid = 0;
    do_reset();
    send(CMD_GO, 0, 0);
    idle();
    repeat (4) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    check("lit_hreset_crst", 32'(core_rst_n), 0);
    check("lit_hreset_count", 32'(wr_count), 0);
    repeat (20) @(negedge clk);
    check("lit_hreset_stays", 32'(core_rst_n), 0);
    check("lit_hreset_ready", 32'(cmd_ready), 1);
`ifdef NX_LOADER_CHECKSUM_EN
    do_reset();
    send(CMD_INST, 0, 32'h10);
    send(CMD_INST, 4, 32'h20);
    send(CMD_GO, 0, 32'h31);
    idle();
    check("lit_cs_bad_err", 32'(load_err), 1);
    check("lit_cs_bad_ready", 32'(cmd_ready), 1);
    check("lit_cs_value", checksum, 32'h30);
    send(CMD_GO, 0, 32'h30);
    idle();
    repeat (16) @(negedge clk);
    check("lit_cs_hold16", 32'(core_rst_n), 0);
    @(negedge clk);
    check("lit_cs_hold17", 32'(core_rst_n), 1);
`endif
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst_n = !($urandom_range(0, 199) == 0 || (m_crst && $urandom_range(0, 7) == 0));
      cmd_valid = $urandom_range(0, 3) != 0;
      cmd_type = $urandom_range(0, 39) == 0 ? CMD_GO : 2'($urandom_range(0, 2));
      cmd_addr = rand_addr(cmd_type);
      cmd_data = $urandom;
`ifdef NX_LOADER_CHECKSUM_EN
      if (cmd_type == CMD_GO && $urandom_range(0, 1) == 1) cmd_data = m_sum;
`endif
    end
    idle();
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
